button_event_decoder: RTL and testbench
=======================================

// Module: button_event_decoder
// PURPOSE
//  Downstream end of the switch path: consumes one debounced, active-high switch
//  level and produces single-cycle Press/Release/LongPress/Repeat events plus a Held
//  level for the sale-terminal key-handling FSMs. One clock domain; input already
//  synchronised and debounced upstream.
// PARAMETERS
//  CNT_WIDTH          16    width of hold/repeat counters
//  LONG_PRESS_CYCLES  1000  cycles held (counted from PressPulse) before LongPress
//  REPEAT_CYCLES      200   cycles between RepeatPulse after LongPress
// PORTS
//  CLK           in   1  clock
//  RST           in   1  asynchronous reset, active high
//  CleanSWIn     in   1  debounced switch level, 1 = pressed
//  PressPulse    out  1  1-cycle pulse on accepted press
//  ReleasePulse  out  1  1-cycle pulse on release of an accepted press
//  LongPress     out  1  1-cycle pulse when hold reaches LONG_PRESS_CYCLES
//  RepeatPulse   out  1  1-cycle pulse every REPEAT_CYCLES while in LONG
//  Held          out  1  level, 1 while in PRESSED or LONG
// BEHAVIOUR
//  - All outputs registered; reset: all outputs 0, state WAIT_LOW, counters 0.
//  - States: WAIT_LOW, IDLE, PRESSED, LONG (2-bit encoding).
//  - WAIT_LOW: -> IDLE on first sampled CleanSWIn=0; a switch held through reset
//    produces no events until it is released once.
//  - IDLE: sampled CleanSWIn=1 -> PRESSED; PressPulse=1 and Held=1 next cycle
//    (latency 1 clock from sampling edge); hold counter loaded 0.
//  - PRESSED: counter +1 per cycle; on sampled 0 -> IDLE, ReleasePulse=1, Held=0.
//    When counter == LONG_PRESS_CYCLES-1 and input still 1 -> LONG, LongPress=1,
//    repeat counter loaded 0.
//  - LONG: repeat counter +1 per cycle; at REPEAT_CYCLES-1 RepeatPulse=1 and counter
//    wraps to 0. Sampled 0 -> IDLE, ReleasePulse=1, counters cleared.
//  - Simultaneous release and threshold (LongPress or Repeat) in same cycle:
//    release wins; only ReleasePulse asserted.
//  - At most one of Press/Release/LongPress/Repeat high in any cycle.
//  - Counters never overflow: compare is ==; CNT_WIDTH must hold max(param)-1
//    (elaboration-time check, error if violated). Params >= 2.
//  - RST asserted mid-press: outputs clear immediately; no ReleasePulse emitted.
// CONFIGURATION
//  BUTTON_AUTOREPEAT_EN defined: LONG-state repeat counter and RepeatPulse as above.
//  Not defined: repeat counter not built, RepeatPulse tied 0, LONG waits for release
//  only; all other behaviour identical.
// STRUCTURE
//  Shared package/include: state encoding localparams (ST_WAIT_LOW, ST_IDLE,
//  ST_PRESSED, ST_LONG) and event-bit index constants reused by key FSMs.
//  One natural sub-module: button_hold_counter (clear/enable/terminal-count
//  comparator), instantiated for hold and, when enabled, repeat counting.
// TESTING (LONG_PRESS_CYCLES=8, REPEAT_CYCLES=3)
//  1 Reset with CleanSWIn=1, release, press 2 cycles -> no events until release;
//    then PressPulse 1 cycle after rise, ReleasePulse 1 cycle after fall.
//  2 Hold 20 cycles -> LongPress exactly 8 cycles after PressPulse; RepeatPulse
//    every 3 cycles thereafter (macro on), none (macro off); one ReleasePulse.
//  3 Release on the cycle counter hits 7 -> ReleasePulse only, no LongPress.
//  4 RST pulsed while in LONG -> all outputs 0 same cycle, no ReleasePulse;
//    subsequent press requires prior low.
//  5 Back-to-back 1-cycle press/1-cycle gap x4 -> 4 Press and 4 Release pulses,
//    never two event outputs high together, Held mirrors accepted presses.
//  6 CNT_WIDTH=2 with LONG_PRESS_CYCLES=8 -> elaboration error.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// Shared state encoding and event-bit indices for the button event decoder and
// the key-handling FSMs that consume its events.
package button_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_LONG     = 2'd3
    } button_state_t;

    localparam int EV_PRESS      = 0;
    localparam int EV_RELEASE    = 1;
    localparam int EV_LONG_PRESS = 2;
    localparam int EV_REPEAT     = 3;
    localparam int EV_COUNT      = 4;

    // True when 'value' is representable as an unsigned number of 'width' bits.
    function automatic bit fits_width(input int value, input int width);
        return (width >= 31) || (value < (1 << width));
    endfunction

endpackage

// File: rtl/button_hold_counter.sv
// Clearable, enabled up-counter that flags (and wraps on) its terminal value
// TERMINAL-1; used for hold-time and auto-repeat counting.
module button_hold_counter
    import button_event_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int TERMINAL  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TERMINAL - 1);

    logic [CNT_WIDTH-1:0] count;

    if (TERMINAL < 2 || !fits_width(TERMINAL - 1, CNT_WIDTH)) begin : g_bad_terminal
        $error("button_hold_counter: TERMINAL-1 must be >= 1 and fit in CNT_WIDTH bits");
    end

    assign terminal = (count == LAST);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced switch level into Press/Release/LongPress/Repeat pulses and a
// Held level. Define BUTTON_AUTOREPEAT_EN to build the LONG-state auto-repeat.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int CNT_WIDTH         = 16,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int REPEAT_CYCLES     = 200
) (
    input  logic CLK,
    input  logic RST,
    input  logic CleanSWIn,
    output logic PressPulse,
    output logic ReleasePulse,
    output logic LongPress,
    output logic RepeatPulse,
    output logic Held
);

    if (LONG_PRESS_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("button_event_decoder: LONG_PRESS_CYCLES and REPEAT_CYCLES must be >= 2");
    end
    if (!fits_width(LONG_PRESS_CYCLES - 1, CNT_WIDTH) ||
        !fits_width(REPEAT_CYCLES - 1, CNT_WIDTH)) begin : g_bad_width
        $error("button_event_decoder: CNT_WIDTH too narrow for max(LONG_PRESS_CYCLES, REPEAT_CYCLES)-1");
    end

    button_state_t         state;
    logic [EV_COUNT-1:0]   events;
    logic                  hold_done;
    logic                  repeat_done;

    button_hold_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERMINAL  (LONG_PRESS_CYCLES)
    ) u_hold_counter (
        .clk      (CLK),
        .rst      (RST),
        .clear    (state != ST_PRESSED),
        .enable   (state == ST_PRESSED),
        .terminal (hold_done)
    );

`ifdef BUTTON_AUTOREPEAT_EN
    button_hold_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERMINAL  (REPEAT_CYCLES)
    ) u_repeat_counter (
        .clk      (CLK),
        .rst      (RST),
        .clear    (state != ST_LONG),
        .enable   (state == ST_LONG),
        .terminal (repeat_done)
    );
`else
    assign repeat_done = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_WAIT_LOW;
            events <= '0;
            Held   <= 1'b0;
        end else begin
            events <= '0;
            case (state)
                ST_WAIT_LOW: begin
                    if (!CleanSWIn) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (CleanSWIn) begin
                        state            <= ST_PRESSED;
                        events[EV_PRESS] <= 1'b1;
                        Held             <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release takes priority over a threshold hit in the same cycle.
                    if (!CleanSWIn) begin
                        state              <= ST_IDLE;
                        events[EV_RELEASE] <= 1'b1;
                        Held               <= 1'b0;
                    end else if (hold_done) begin
                        state                 <= ST_LONG;
                        events[EV_LONG_PRESS] <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!CleanSWIn) begin
                        state              <= ST_IDLE;
                        events[EV_RELEASE] <= 1'b1;
                        Held               <= 1'b0;
                    end else if (repeat_done) begin
                        events[EV_REPEAT] <= 1'b1;
                    end
                end
                default: state <= ST_WAIT_LOW;
            endcase
        end
    end

    assign PressPulse   = events[EV_PRESS];
    assign ReleasePulse = events[EV_RELEASE];
    assign LongPress    = events[EV_LONG_PRESS];
    assign RepeatPulse  = events[EV_REPEAT];

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=3;
// expectations follow BUTTON_AUTOREPEAT_EN when it is defined.
module tb_button_event_decoder;

    localparam int LP = 8;
    localparam int RP = 3;

    // Observed/expected vector layout: {Held, RepeatPulse, LongPress, ReleasePulse, PressPulse}
    localparam logic [4:0] V_NONE    = 5'b00000;
    localparam logic [4:0] V_PRESS   = 5'b10001;
    localparam logic [4:0] V_HELD    = 5'b10000;
    localparam logic [4:0] V_LONG    = 5'b10100;
    localparam logic [4:0] V_REPEAT  = 5'b11000;
    localparam logic [4:0] V_RELEASE = 5'b00010;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CleanSWIn = 1'b1;
    logic PressPulse, ReleasePulse, LongPress, RepeatPulse, Held;

    int total = 0;
    int bad   = 0;
    int press_seen   = 0;
    int release_seen = 0;

    button_event_decoder #(
        .CNT_WIDTH         (16),
        .LONG_PRESS_CYCLES (LP),
        .REPEAT_CYCLES     (RP)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CleanSWIn    (CleanSWIn),
        .PressPulse   (PressPulse),
        .ReleasePulse (ReleasePulse),
        .LongPress    (LongPress),
        .RepeatPulse  (RepeatPulse),
        .Held         (Held)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {Held, RepeatPulse, LongPress, ReleasePulse, PressPulse};
    endfunction

    // Drive the input, clock one edge, then sample 1 time unit after the edge.
    task automatic step(input string tag, input logic level, input logic [4:0] exp);
        logic [4:0] v;
        CleanSWIn = level;
        @(posedge CLK);
        #1;
        v = outs();
        check(tag, {27'd0, v}, {27'd0, exp});
        check({tag, "_onehot"}, (($countones(v[3:0]) <= 1) ? 32'd1 : 32'd0), 32'd1);
        if (v[0]) press_seen++;
        if (v[1]) release_seen++;
    endtask

    // Expected outputs k cycles after the press-sampling edge while still held.
    function automatic logic [4:0] hold_exp(input int k);
        if (k == 0)  return V_PRESS;
        if (k == LP) return V_LONG;
`ifdef BUTTON_AUTOREPEAT_EN
        if (k > LP && ((k - LP) % RP) == 0) return V_REPEAT;
`endif
        return V_HELD;
    endfunction

    task automatic hold_press(input string tag, input int cycles);
        for (int k = 0; k <= cycles; k++) step(tag, 1'b1, hold_exp(k));
    endtask

    initial begin
        // 1: switch held through reset yields nothing until released once
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outs", {27'd0, outs()}, 32'd0);
        RST = 1'b0;
        step("t1_held_after_reset", 1'b1, V_NONE);
        step("t1_held_after_reset", 1'b1, V_NONE);
        step("t1_first_low", 1'b0, V_NONE);
        step("t1_press", 1'b1, V_PRESS);
        step("t1_hold", 1'b1, V_HELD);
        step("t1_release", 1'b0, V_RELEASE);
        step("t1_idle", 1'b0, V_NONE);

        // 2: long hold, LongPress 8 cycles after PressPulse, repeats every 3 when built
        hold_press("t2_hold", 19);
        step("t2_release", 1'b0, V_RELEASE);
        step("t2_idle", 1'b0, V_NONE);

        // 3: release on the same edge the hold threshold is reached
        hold_press("t3_hold", LP - 1);
        step("t3_release_wins", 1'b0, V_RELEASE);
        step("t3_idle", 1'b0, V_NONE);

        // 4: reset while in LONG clears outputs immediately, no ReleasePulse
        hold_press("t4_hold", LP + 1);
        #2 RST = 1'b1;
        #1;
        check("t4_async_reset", {27'd0, outs()}, 32'd0);
        #1 RST = 1'b0;
        step("t4_wait_low", 1'b1, V_NONE);
        step("t4_wait_low", 1'b1, V_NONE);
        step("t4_first_low", 1'b0, V_NONE);
        step("t4_press", 1'b1, V_PRESS);
        step("t4_release", 1'b0, V_RELEASE);

        // 5: back-to-back one-cycle presses
        press_seen   = 0;
        release_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step("t5_press", 1'b1, V_PRESS);
            step("t5_release", 1'b0, V_RELEASE);
        end
        check("t5_press_count", press_seen, 32'd4);
        check("t5_release_count", release_seen, 32'd4);
        step("t5_idle", 1'b0, V_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
